// File: rtl/usb_rx.sv
// usb_rx: low-speed USB receive front end (4x oversampled, UTMI-style)
// DPLL bit recovery, NRZI decode, unstuffing, SYNC/EOP framing, deserializer
module usb_rx #(
  parameter int SYNC_MIN_ZEROS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d,
  output logic [1:0] line_state,
  output logic [7:0] data,
  output logic       active,
  output logic       valid,
  output logic       error
);

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    WAIT_EOP,
    EOP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] s1_q, s1_d;
  logic [1:0] ls_q, ls_d;
  logic [1:0] sym_q, sym_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] prev_q, prev_d;
  logic [2:0] zcnt_q, zcnt_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       active_q, active_d;

  logic       trans;
  logic       smp;
  logic       is_se;
  logic       bit_v;

  // Synchronizer, DPLL phase and the receive datapath next-state logic
  always_comb begin
    s1_d     = d;
    ls_d     = s1_q;
    sym_d    = ls_q;
    trans    = ((ls_q == J) || (ls_q == K)) &&
               ((sym_q == J) || (sym_q == K)) &&
               (ls_q != sym_q);
    phase_d  = trans ? 2'd0 : phase_q + 2'd1;
    smp      = (phase_q == 2'd2);
    is_se    = (sym_q == SE0) || (sym_q == SE1);
    bit_v    = (sym_q == prev_q);
    state_d  = state_q;
    prev_d   = prev_q;
    zcnt_d   = zcnt_q;
    ones_d   = ones_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        prev_d = J;
        if (smp && (sym_q == K)) begin
          prev_d  = K;
          zcnt_d  = 3'd1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (smp) begin
          if (is_se) begin
            state_d = IDLE;
          end else begin
            prev_d = sym_q;
            if (!bit_v) begin
              if (zcnt_q != 3'd7) zcnt_d = zcnt_q + 3'd1;
            end else if (int'(zcnt_q) >= SYNC_MIN_ZEROS) begin
              active_d = 1'b1;
              ones_d   = 3'd1;
              bcnt_d   = 3'd0;
              state_d  = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (smp) begin
          if (is_se) begin
            error_d = (bcnt_q != 3'd0);
            state_d = EOP;
          end else begin
            prev_d = sym_q;
            if (ones_q == 3'd6) begin
              ones_d = 3'd0;
              if (bit_v) begin
                error_d = 1'b1;
                state_d = WAIT_EOP;
              end
            end else begin
              ones_d = bit_v ? ones_q + 3'd1 : 3'd0;
              sh_d   = {bit_v, sh_q[7:1]};
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                data_d  = {bit_v, sh_q[7:1]};
                valid_d = 1'b1;
              end
            end
          end
        end
      end
      WAIT_EOP: begin
        if (smp && is_se) state_d = EOP;
      end
      EOP: begin
        if (smp && !is_se) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      s1_q     <= J;
      ls_q     <= J;
      sym_q    <= J;
      phase_q  <= 2'd0;
      prev_q   <= J;
      zcnt_q   <= 3'd0;
      ones_q   <= 3'd0;
      bcnt_q   <= 3'd0;
      sh_q     <= 8'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      ls_q     <= ls_d;
      sym_q    <= sym_d;
      phase_q  <= phase_d;
      prev_q   <= prev_d;
      zcnt_q   <= zcnt_d;
      ones_q   <= ones_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      active_q <= active_d;
    end
  end

  assign line_state = ls_q;
  assign data       = data_q;
  assign valid      = valid_q;
  assign error      = error_q;
  assign active     = active_q;

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: directed packets driven as line symbols,
// expected bytes/errors queued and checked as the DUT emits them
`timescale 1ns/1ps
module tb_usb_rx;

  localparam realtime TCLK  = 166.0;
  localparam realtime THALF = 83.0;
  localparam realtime TBIT  = 664.0;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] d;
  logic [1:0] line_state;
  logic [7:0] data;
  logic       active;
  logic       valid;
  logic       error;

  int   errors = 0;
  int   checks = 0;
  int   rises  = 0;
  logic act_prev = 1'b0;
  exp_t exp_q[$];

  logic [1:0] cur;
  int         ones;

  usb_rx #(.SYNC_MIN_ZEROS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .line_state(line_state),
    .data      (data),
    .active    (active),
    .valid     (valid),
    .error     (error)
  );

  always #(THALF) clk = ~clk;

  // Scoreboard: compare every valid/error strobe against the queue
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (active === 1'b1 && act_prev === 1'b0) rises++;
      act_prev = active;
      if (valid === 1'b1 || error === 1'b1) begin
        checks++;
        assert (!(valid === 1'b1 && error === 1'b1)) else begin
          errors++;
          $error("FAIL both_strobes got v=%b e=%b exp one", valid, error);
        end
        checks++;
        assert (active === 1'b1) else begin
          errors++;
          $error("FAIL strobe_inactive got active=%b exp 1", active);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected got v=%b e=%b d=%h exp none",
                 valid, error, data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          assert (error === e.is_err) else begin
            errors++;
            $error("FAIL kind got err=%b exp err=%b", error, e.is_err);
          end
          if (!e.is_err) begin
            checks++;
            assert (data === e.val) else begin
              errors++;
              $error("FAIL byte got %h exp %h", data, e.val);
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.val    = b;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.val    = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic tx_bit(input bit b, input bit stuff);
    if (!b) cur = (cur == J) ? K : J;
    d = cur;
    #(TBIT);
    ones = b ? ones + 1 : 0;
    if (stuff && ones == 6) begin
      cur = (cur == J) ? K : J;
      d = cur;
      #(TBIT);
      ones = 0;
    end
  endtask

  task automatic tx_bits(input logic [7:0] v, input int n, input bit stuff);
    for (int i = 0; i < n; i++) tx_bit(v[i], stuff);
  endtask

  task automatic tx_sync();
    cur  = J;
    ones = 0;
    for (int i = 0; i < 7; i++) tx_bit(1'b0, 1'b1);
    tx_bit(1'b1, 1'b1);
  endtask

  task automatic tx_eop(input int n);
    d = SE0;
    #(TBIT * n);
    d   = J;
    cur = J;
    #(TBIT);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (active !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_active"}, {31'd0, active}, 32'd0);
    check({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] pay [10];
    int r0;
    pay = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
            8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h22};
    reset = 1'b0;
    d     = J;
    cur   = J;
    ones  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_line", {30'd0, line_state}, {30'd0, J});
    @(posedge clk);
    #(0.3 * TCLK);
    reset = 1'b1;
    #(TBIT * 3);

    r0 = rises;
    push_byte(8'hC3);
    foreach (pay[i]) push_byte(pay[i]);
    tx_sync();
    tx_bits(8'hC3, 8, 1'b1);
    foreach (pay[i]) tx_bits(pay[i], 8, 1'b1);
    tx_eop(2);
    wait_idle("pkt_data0");
    check("pkt_data0_rise", rises - r0, 32'd1);

    r0 = rises;
    push_byte(8'h4B);
    push_byte(8'hFF);
    push_byte(8'hFF);
    tx_sync();
    tx_bits(8'h4B, 8, 1'b1);
    tx_bits(8'hFF, 8, 1'b1);
    tx_bits(8'hFF, 8, 1'b1);
    tx_eop(2);
    wait_idle("stuffed");
    check("stuffed_rise", rises - r0, 32'd1);

    r0 = rises;
    push_byte(8'hC3);
    push_err();
    tx_sync();
    tx_bits(8'hC3, 8, 1'b1);
    tx_bits(8'hFF, 8, 1'b0);
    tx_bits(8'h5A, 8, 1'b1);
    tx_eop(2);
    wait_idle("stuff_err");
    check("stuff_err_rise", rises - r0, 32'd1);

    r0 = rises;
    push_byte(8'hC3);
    push_err();
    tx_sync();
    tx_bits(8'hC3, 8, 1'b1);
    tx_bits(8'hA5, 5, 1'b1);
    tx_eop(1);
    wait_idle("partial");
    check("partial_rise", rises - r0, 32'd1);

    r0 = rises;
    push_byte(8'hC3);
    push_byte(8'h12);
    push_byte(8'h34);
    tx_sync();
    tx_bits(8'hC3, 8, 1'b1);
    tx_bits(8'h12, 8, 1'b1);
    tx_bits(8'h34, 8, 1'b1);
    tx_eop(2);
    #(TBIT * 2);
    #(0.6 * TCLK);
    push_byte(8'h4B);
    push_byte(8'hAB);
    push_byte(8'hCD);
    tx_sync();
    tx_bits(8'h4B, 8, 1'b1);
    tx_bits(8'hAB, 8, 1'b1);
    tx_bits(8'hCD, 8, 1'b1);
    tx_eop(2);
    wait_idle("b2b");
    check("b2b_rises", rises - r0, 32'd2);
    check("final_line", {30'd0, line_state}, {30'd0, J});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
